// File: rtl/bcd_multidigit_timer.sv
// Multi-digit BCD up/down timer with per-digit wrap limits and run control.
// Optional BCD_TIMER_AUTORELOAD_EN: terminal count reloads the last loaded value.
module bcd_multidigit_timer #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  dir,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic [4*DIGITS-1:0]   limit,
   output logic [4*DIGITS-1:0]   value,
   output logic                  running,
   output logic                  done
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   value_q, value_d;
   logic           running_q;
   logic           done_q, done_d;
   logic [W-1:0]   reload_v;

   function automatic logic [W-1:0] clamp_f(
      input logic [W-1:0] v,
      input logic [W-1:0] lim
   );
      logic [W-1:0] o;
      o = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > lim[4*i +: 4])
            o[4*i +: 4] = lim[4*i +: 4];
      end
      return o;
   endfunction

   // Ripple one BCD step through the digits; carry/borrow starts at digit 0.
   function automatic logic [W-1:0] step_f(
      input logic [W-1:0] v,
      input logic [W-1:0] lim,
      input logic         down
   );
      logic [W-1:0] o;
      logic [3:0]   d;
      logic [3:0]   l;
      logic         c;
      o = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         l = lim[4*i +: 4];
         if (c) begin
            if (down) begin
               if (d == 4'd0) begin
                  d = l;
               end else begin
                  d = d - 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (d >= l) begin
                  d = 4'd0;
               end else begin
                  d = d + 4'd1;
                  c = 1'b0;
               end
            end
         end
         o[4*i +: 4] = d;
      end
      return o;
   endfunction

   function automatic logic term_f(
      input logic [W-1:0] v,
      input logic [W-1:0] lim,
      input logic         down
   );
      logic t;
      t = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (down && v[4*i +: 4] != 4'd0)
            t = 1'b0;
         if (!down && v[4*i +: 4] != lim[4*i +: 4])
            t = 1'b0;
      end
      return t;
   endfunction

`ifdef BCD_TIMER_AUTORELOAD_EN
   logic [W-1:0] reload_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         reload_q <= '0;
      else if (load)
         reload_q <= clamp_f(load_value, limit);
   end

   assign reload_v = reload_q;
`else
   assign reload_v = '0;
`endif

   always_comb begin
      logic [W-1:0] stepped;
      logic         hit;
      state_d = state_q;
      value_d = value_q;
      done_d  = 1'b0;
      hit     = 1'b0;
      stepped = step_f(value_q, limit, dir);
      if (load) begin
         value_d = clamp_f(load_value, limit);
         state_d = S_IDLE;
      end else if (pause && state_q == S_RUN) begin
         state_d = S_PAUSE;
      end else if (start &&
                   (state_q == S_IDLE || state_q == S_PAUSE)) begin
         state_d = S_RUN;
      end else if (state_q == S_RUN && tick) begin
         // Already terminal on entry: no step, just finish.
         if (term_f(value_q, limit, dir)) begin
            hit = 1'b1;
         end else begin
            value_d = stepped;
            hit     = term_f(stepped, limit, dir);
         end
         if (hit) begin
            done_d = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
            value_d = reload_v;
`else
            state_d = S_DONE;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         value_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         running_q <= (state_d == S_RUN);
         done_q    <= done_d;
      end
   end

   assign value   = value_q;
   assign running = running_q;
   assign done    = done_q;

   logic unused_reload;
   assign unused_reload = ^reload_v;

endmodule

// File: tb/tb_bcd_multidigit_timer.sv
// Self-checking bench for bcd_multidigit_timer (DIGITS=4, limit 5959).
// Reference model counts as a mixed-radix integer.
module tb_bcd_multidigit_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        dir = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_value = '0;
   logic [15:0] limit = 16'h5959;
   logic [15:0] value;
   logic        running;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   localparam int MI = 0, MR = 1, MP = 2, MD = 3;
   int   m_n  = 0;
   int   m_rl = 0;
   int   m_st = MI;
   logic m_done = 1'b0;

   bcd_multidigit_timer #(.DIGITS(4)) dut (
      .clk(clk), .rst(rst), .tick(tick), .dir(dir),
      .start(start), .pause(pause), .load(load),
      .load_value(load_value), .limit(limit),
      .value(value), .running(running), .done(done)
   );

   always #5 clk = ~clk;

   function automatic int radix(input int i);
      return int'(limit[4*i +: 4]) + 1;
   endfunction

   function automatic int total();
      int t = 1;
      for (int i = 0; i < 4; i++) t = t * radix(i);
      return t;
   endfunction

   function automatic int to_int(input logic [15:0] v);
      int n = 0;
      for (int i = 3; i >= 0; i--) begin
         int d = int'(v[4*i +: 4]);
         if (d > int'(limit[4*i +: 4])) d = int'(limit[4*i +: 4]);
         n = n * radix(i) + d;
      end
      return n;
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] v = '0;
      int r = n;
      for (int i = 0; i < 4; i++) begin
         v[4*i +: 4] = 4'(r % radix(i));
         r = r / radix(i);
      end
      return v;
   endfunction

   function automatic logic is_term(input int n, input logic down);
      return down ? (n == 0) : (n == total() - 1);
   endfunction

   task automatic model_apply();
      m_done = 1'b0;
      if (rst) begin
         m_n = 0;
         m_rl = 0;
         m_st = MI;
      end else if (load) begin
         m_n = to_int(load_value);
         m_rl = m_n;
         m_st = MI;
      end else if (pause && m_st == MR) begin
         m_st = MP;
      end else if (start && (m_st == MI || m_st == MP)) begin
         m_st = MR;
      end else if (m_st == MR && tick) begin
         if (!is_term(m_n, dir))
            m_n = dir ? m_n - 1 : m_n + 1;
         if (is_term(m_n, dir)) begin
            m_done = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
            m_n = m_rl;
`else
            m_st = MD;
`endif
         end
      end
   endtask

   task automatic clk_edge();
      @(posedge clk);
      model_apply();
      #1;
   endtask

   task automatic idle_in();
      tick = 0; start = 0; pause = 0; load = 0;
   endtask

   task automatic do_load(input logic [15:0] v);
      idle_in(); load = 1; load_value = v;
      clk_edge();
      load = 0;
   endtask

   task automatic do_start();
      idle_in(); start = 1;
      clk_edge();
      start = 0;
   endtask

   task automatic do_tick(input logic d);
      idle_in(); tick = 1; dir = d;
      clk_edge();
      tick = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle_in();
      clk_edge(); clk_edge();
      n_cmp++;
      if (value !== 16'h0 || running !== 0 || done !== 0) begin
         n_err++;
         $display("FAIL reset_init: value=%h run=%b done=%b want 0000/0/0",
                  value, running, done);
      end
      rst = 0;
      clk_edge();
      do_load(16'h0100); do_start();
      do_tick(1'b1); do_tick(1'b1);
      #3 rst = 1;
      m_n = 0; m_st = MI; m_rl = 0; m_done = 0;
      #1;
      n_cmp++;
      if (value !== 16'h0 || running !== 0 || done !== 0) begin
         n_err++;
         $display("FAIL reset_async: value=%h run=%b done=%b want 0000/0/0",
                  value, running, done);
      end
      clk_edge();
      rst = 0;
      do_load(16'h0100);
      n_cmp++;
      if (value !== 16'h0100 || running !== 0) begin
         n_err++;
         $display("FAIL reset_load: value=%h run=%b want 0100/0",
                  value, running);
      end
   endtask

   task automatic test_down_borrow();
      do_load(16'h0100); do_start();
      n_cmp++;
      if (running !== 1) begin
         n_err++;
         $display("FAIL start_run: running=%b want 1", running);
      end
      do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h0059) begin
         n_err++;
         $display("FAIL borrow_chain: value=%h want 0059", value);
      end
      for (int i = 0; i < 3; i++) do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h0056) begin
         n_err++;
         $display("FAIL borrow_more: value=%h want 0056", value);
      end
   endtask

`ifndef BCD_TIMER_AUTORELOAD_EN
   task automatic test_down_terminal();
      do_load(16'h0002); do_start();
      do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h0001 || done !== 0 || running !== 1) begin
         n_err++;
         $display("FAIL term_pre: value=%h done=%b run=%b want 0001/0/1",
                  value, done, running);
      end
      do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h0000 || done !== 1 || running !== 0) begin
         n_err++;
         $display("FAIL term_hit: value=%h done=%b run=%b want 0000/1/0",
                  value, done, running);
      end
      do_tick(1'b1);
      n_cmp++;
      if (done !== 0 || value !== 16'h0000) begin
         n_err++;
         $display("FAIL term_pulse: done=%b value=%h want 0/0000",
                  done, value);
      end
      do_start(); do_tick(1'b1); do_tick(1'b0);
      n_cmp++;
      if (value !== 16'h0000 || running !== 0 || done !== 0) begin
         n_err++;
         $display("FAIL term_hold: value=%h run=%b done=%b want 0000/0/0",
                  value, running, done);
      end
   endtask
`else
   task automatic test_autoreload();
      do_load(16'h0001); do_start();
      do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h0001 || done !== 1 || running !== 1) begin
         n_err++;
         $display("FAIL reload_1: value=%h done=%b run=%b want 0001/1/1",
                  value, done, running);
      end
      do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h0001 || done !== 1 || running !== 1) begin
         n_err++;
         $display("FAIL reload_2: value=%h done=%b run=%b want 0001/1/1",
                  value, done, running);
      end
      idle_in(); clk_edge();
      n_cmp++;
      if (done !== 0) begin
         n_err++;
         $display("FAIL reload_pulse: done=%b want 0", done);
      end
   endtask
`endif

   task automatic test_up_dir();
      do_load(16'h0058); do_start();
      do_tick(1'b0);
      n_cmp++;
      if (value !== 16'h0059) begin
         n_err++;
         $display("FAIL up_step: value=%h want 0059", value);
      end
      do_tick(1'b0);
      n_cmp++;
      if (value !== 16'h0100) begin
         n_err++;
         $display("FAIL up_carry: value=%h want 0100", value);
      end
      do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h0059) begin
         n_err++;
         $display("FAIL dir_change: value=%h want 0059", value);
      end
   endtask

   task automatic test_priority();
      do_load(16'h7A3C);
      n_cmp++;
      if (value !== 16'h5939) begin
         n_err++;
         $display("FAIL clamp: value=%h want 5939", value);
      end
      do_start();
      idle_in(); pause = 1; start = 1; tick = 1; dir = 1;
      clk_edge();
      n_cmp++;
      if (running !== 0 || value !== 16'h5939) begin
         n_err++;
         $display("FAIL pause_start: run=%b value=%h want 0/5939",
                  running, value);
      end
      for (int i = 0; i < 3; i++) do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h5939) begin
         n_err++;
         $display("FAIL pause_hold: value=%h want 5939", value);
      end
      do_start();
      idle_in(); load = 1; pause = 1; load_value = 16'h0123;
      clk_edge();
      idle_in();
      n_cmp++;
      if (value !== 16'h0123 || running !== 0) begin
         n_err++;
         $display("FAIL load_pause: value=%h run=%b want 0123/0",
                  value, running);
      end
      do_tick(1'b1);
      n_cmp++;
      if (value !== 16'h0123) begin
         n_err++;
         $display("FAIL idle_tick: value=%h want 0123", value);
      end
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 600; c++) begin
         idle_in();
         r = $urandom_range(0, 99);
         if (r < 5) begin
            load = 1;
            case ($urandom_range(0, 2))
               0: load_value = to_bcd($urandom_range(0, 4));
               1: load_value = to_bcd(total() - 1 - $urandom_range(0, 4));
               default: load_value = 16'($urandom);
            endcase
            pause = $urandom_range(0, 1) == 1;
         end else if (r < 9) begin
            pause = 1;
            start = (m_st == MR) && ($urandom_range(0, 1) == 1);
         end else if (r < 18) begin
            start = 1;
         end
         tick = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         clk_edge();
         n_cmp++;
         if (value !== to_bcd(m_n) || running !== (m_st == MR) ||
             done !== m_done) begin
            n_err++;
            $display("FAIL random c=%0d: value=%h run=%b done=%b want %h/%b/%b",
                     c, value, running, done, to_bcd(m_n),
                     (m_st == MR), m_done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_down_borrow();
`ifndef BCD_TIMER_AUTORELOAD_EN
      test_down_terminal();
`else
      test_autoreload();
`endif
      test_up_dir();
      test_priority();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_multidigit_timer.md
# bcd_multidigit_timer

Parametrised multi-digit BCD up/down timer for the digital-watch datapath. It chains DIGITS BCD digit stages, each with its own wrap limit, so it can count a stopwatch (MM:SS, HH:MM) or a countdown timer. It adds start, pause and load control, a runtime count direction, terminal-count detection and a done pulse. It replaces hand-chained single-digit counters and is driven by the one-second tick from the prescaler.

## Interface
- DIGITS, 4, number of BCD digit stages (≥1); digit 0 is least significant
- clk  input  1  global clock
- rst  input  1  reset, asynchronous, active-high
- tick  input  1  count-enable strobe, one step per cycle it is high while RUN
- dir  input  1  1 = count down, 0 = count up; sampled on every counting tick
- start  input  1  IDLE/PAUSE → RUN
- pause  input  1  RUN → PAUSE
- load  input  1  value ← load_value (clamped), state → IDLE
- load_value  input  4*DIGITS  BCD preset, digit i at bits [4i+3:4i]
- limit  input  4*DIGITS  per-digit maximum (e.g. 5 for tens-of-seconds, 9 otherwise)
- value  output  4*DIGITS  current BCD count
- running  output  1  high while state is RUN
- done  output  1  one-cycle pulse on terminal count

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset: value = 0, state = IDLE, running = 0, done = 0.
- Command priority: load > pause > start.
  - load is accepted in any state.
  - start is accepted only in IDLE or PAUSE.
  - start in RUN or DONE is ignored.
  - pause outside RUN is ignored.
- Load clamp: any load_value digit greater than its limit digit is replaced by that limit.
- Counting happens only in RUN, with tick=1 and no load or pause in the same cycle.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 wraps to limit[i] and borrows into digit i+1.
  - A borrow into a digit means it decrements (or wraps) too.
- Up step:
  - Digit 0 increments.
  - A digit at limit[i] wraps to 0 and carries into digit i+1.
  - Wrap out of the top digit is discarded.
- Terminal value:
  - Counting down: all digits 0.
  - Counting up: every digit equal to its limit.
- If a tick step produces the terminal value, state becomes DONE on that same edge.
- If RUN is entered with value already terminal, the next tick does not step; it goes straight to DONE (value unchanged).
- dir may change while running; each step uses the dir value sampled at that edge.
- DONE holds value; only load exits it.
- A limit digit of 0 makes that digit constantly 0, which is legal.

## Timing
- All state, value, running and done are registered; there are no combinational paths from inputs to outputs.
- value changes on the rising clk edge at which tick is sampled high in RUN.
- The load, start and pause effects are visible in the cycle after the sampling edge.
- done is high for exactly one cycle, the cycle following the terminal edge.
- running is high from the cycle after start through the cycle of the terminal edge.
- Asserting rst mid-count forces the reset values immediately, regardless of clk.
- rst release takes effect on the next clock edge.

## Configuration
- BCD_TIMER_AUTORELOAD_EN defined:
  - On terminal count, value ← clamped load_value, as captured at the most recent load.
  - State stays RUN and done still pulses once.
  - Implementation keeps a 4*DIGITS reload register, reset to 0.
- Not defined:
  - Terminal count enters DONE and holds as described above.
  - The reload register is absent.

## Test plan
(All scenarios use DIGITS=4 and limit=16'h5959.)
- Reset/load: assert rst mid-RUN → value=16'h0000, running=0, done=0 immediately; then load 16'h0100 → value=16'h0100, state IDLE.
- Down borrow chain: load 16'h0100, start, dir=1, one tick → value=16'h0059; three more ticks → 16'h0056.
- Down terminal: load 16'h0002, start, two ticks → value=16'h0000, done pulses one cycle, running=0; further ticks and start leave value at 16'h0000.
- Up and direction change: load 16'h0058, start, dir=0, tick → 16'h0059; next tick → 16'h0100; dir=1, tick → 16'h0059.
- Priority/pause/clamp:
  - load_value=16'h7A3C loads as 16'h5939.
  - pause and start together in RUN → PAUSE; ticks in PAUSE leave value unchanged.
  - load with pause → IDLE with the new value.
- Autoreload (macro defined): load 16'h0001, start, tick → done pulse, value=16'h0001, running stays 1; next tick → done pulses again.
